// File: rtl/seg_scan_bcd_ctrl.sv
// N-digit multiplexed 7-segment driver with a one-bit-per-clock double-dabble BCD converter.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module seg_scan_bcd_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int BIN_W          = 32,
    parameter int SCAN_DIV       = 1024,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BIN_W-1:0]      BINARY_SCORE,
    input  logic                  SCORE_LOAD,
    output logic                  CONV_BUSY,
    output logic                  CONV_DONE,
    output logic                  OVERFLOW,
    output logic [NUM_DIGITS-1:0] AR_COM,
    output logic [6:0]            AR_SEG
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] COM_OFF  = COM_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                     state, state_next;
    logic [BIN_W-1:0]           bin_sr, bin_sr_next;
    logic [BCD_W-1:0]           bcd, bcd_next, bcd_adj;
    logic [CNT_W-1:0]           cnt, cnt_next;
    logic                       ovf_work, ovf_work_next;
    logic                       pending, pending_next;
    logic [NUM_DIGITS-1:0][3:0] digits, digits_next;
    logic                       ovf, ovf_next;
    logic                       done, done_next;

    logic [PRE_W-1:0]           pre;
    logic [IDX_W-1:0]           idx;
    logic [NUM_DIGITS-1:0]      com_reg, com_sel;
    logic [6:0]                 seg_reg, seg_lit;
    logic [3:0]                 cur_digit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_work <= 1'b0;
            pending  <= 1'b0;
            digits   <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bin_sr   <= bin_sr_next;
            bcd      <= bcd_next;
            cnt      <= cnt_next;
            ovf_work <= ovf_work_next;
            pending  <= pending_next;
            digits   <= digits_next;
            ovf      <= ovf_next;
            done     <= done_next;
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next    = state;
        bin_sr_next   = bin_sr;
        bcd_next      = bcd;
        cnt_next      = cnt;
        ovf_work_next = ovf_work;
        pending_next  = pending;
        digits_next   = digits;
        ovf_next      = ovf;
        done_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (SCORE_LOAD || pending) begin
                    bin_sr_next   = BINARY_SCORE;
                    bcd_next      = '0;
                    ovf_work_next = 1'b0;
                    pending_next  = 1'b0;
                    cnt_next      = CNT_INIT;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // A carry out of the top nibble means the value needs more digits than fitted.
                bcd_next      = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                bin_sr_next   = {bin_sr[BIN_W-2:0], 1'b0};
                ovf_work_next = ovf_work | bcd_adj[BCD_W-1];
                cnt_next      = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_next = COMMIT;
                if (SCORE_LOAD) pending_next = 1'b1;
            end
            COMMIT: begin
                digits_next = bcd;
                ovf_next    = ovf_work;
                done_next   = 1'b1;
                state_next  = IDLE;
                if (SCORE_LOAD) pending_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank, blank_next;
    logic                  seen_nz;

    always_comb begin
        blank_next = '0;
        seen_nz    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            seen_nz = seen_nz | (bcd[4*(NUM_DIGITS-1-k) +: 4] != 4'd0);
            blank_next[NUM_DIGITS-1-k] = !seen_nz && (k != NUM_DIGITS - 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) blank <= ~NUM_DIGITS'(1);
        else if (state == COMMIT) blank <= blank_next;
    end
`endif

    always_comb begin
        cur_digit = digits[idx];
        com_sel   = NUM_DIGITS'(1) << idx;
        unique case (cur_digit)
            4'd0:    seg_lit = 7'b0111111;
            4'd1:    seg_lit = 7'b0000110;
            4'd2:    seg_lit = 7'b1011011;
            4'd3:    seg_lit = 7'b1001111;
            4'd4:    seg_lit = 7'b1100110;
            4'd5:    seg_lit = 7'b1101101;
            4'd6:    seg_lit = 7'b1111101;
            4'd7:    seg_lit = 7'b0000111;
            4'd8:    seg_lit = 7'b1111111;
            4'd9:    seg_lit = 7'b1101111;
            default: seg_lit = 7'b0000000;
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (blank[idx]) seg_lit = 7'b0000000;
`endif
        if (ovf) seg_lit = 7'b1000000;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre     <= '0;
            idx     <= '0;
            com_reg <= COM_OFF;
            seg_reg <= SEG_OFF;
        end else begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
            com_reg <= COM_ACTIVE_LOW ? ~com_sel : com_sel;
            seg_reg <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        end
    end

    assign CONV_BUSY = (state != IDLE);
    assign CONV_DONE = done;
    assign OVERFLOW  = ovf;
    assign AR_COM    = com_reg;
    assign AR_SEG    = seg_reg;

endmodule

// File: tb/tb_seg_scan_bcd_ctrl.sv
// Directed self-checking bench for seg_scan_bcd_ctrl: default instance plus a small active-high 4-digit instance.
`timescale 1ns/1ps
module tb_seg_scan_bcd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] score_a, score_b;
    logic        load_a, load_b;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [7:0]  com_a;
    logic [3:0]  com_b;
    logic [6:0]  seg_a, seg_b;

    logic [6:0]  slot_a [8];
    logic [6:0]  slot_b [4];

    int errors = 0;
    int checks = 0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    // Expected pattern of a leading-zero slot on each instance.
    localparam logic [6:0] ZA = LZB ? 7'b1111111 : 7'b1000000;
    localparam logic [6:0] ZB = LZB ? 7'b0000000 : 7'b0111111;

    seg_scan_bcd_ctrl #(
        .NUM_DIGITS(8), .BIN_W(32), .SCAN_DIV(1024), .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut_a (
        .CLK(clk), .RST(rst), .BINARY_SCORE(score_a), .SCORE_LOAD(load_a),
        .CONV_BUSY(busy_a), .CONV_DONE(done_a), .OVERFLOW(ovf_a), .AR_COM(com_a), .AR_SEG(seg_a)
    );

    seg_scan_bcd_ctrl #(
        .NUM_DIGITS(4), .BIN_W(32), .SCAN_DIV(4), .COM_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) dut_b (
        .CLK(clk), .RST(rst), .BINARY_SCORE(score_b), .SCORE_LOAD(load_b),
        .CONV_BUSY(busy_b), .CONV_DONE(done_b), .OVERFLOW(ovf_b), .AR_COM(com_b), .AR_SEG(seg_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse SCORE_LOAD for one edge and watch the conversion for a bounded number of cycles.
    task automatic conv_a(input logic [31:0] value, output int done_at, output int busy_cnt, output int n_done);
        score_a = value;
        load_a  = 1'b1;
        tick();
        load_a  = 1'b0;
        busy_cnt = busy_a ? 1 : 0;
        done_at  = -1;
        n_done   = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (busy_a) busy_cnt++;
            if (done_a) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic scan_a();
        int bad;
        int n_act;
        bad = 0;
        for (int c = 0; c < 8*1024 + 4; c++) begin
            tick();
            n_act = 0;
            for (int i = 0; i < 8; i++) begin
                if (!com_a[i]) begin
                    n_act++;
                    slot_a[i] = seg_a;
                end
            end
            if (n_act != 1) bad++;
        end
        check("com_a_onehot", bad, 0);
    endtask

    initial begin
        int done_at, busy_cnt, n_done, bad, found;
        logic [3:0] prev;

        rst = 1'b1; load_a = 1'b0; score_a = '0; load_b = 1'b0; score_b = '0;
        repeat (3) tick();
        check("rst_com_a", com_a, 8'hFF);
        check("rst_seg_a", seg_a, 7'h7F);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_com_b", com_b, 4'h0);
        check("rst_seg_b", seg_b, 7'h00);

        rst = 1'b0;
        tick();
        check("com_first", com_a, 8'hFE);
        check("seg_first", seg_a, 7'b1000000);
        repeat (1023) tick();
        check("com_1024", com_a, 8'hFE);
        tick();
        check("com_rot", com_a, 8'hFD);
        check("ovf_idle", ovf_a, 0);

        conv_a(32'd12345678, done_at, busy_cnt, n_done);
        check("busy_len", busy_cnt, 33);
        check("done_lat", done_at, 33);
        check("done_cnt", n_done, 1);
        check("ovf_1234", ovf_a, 0);
        scan_a();
        check("d1234_s0", slot_a[0], 7'b0000000);
        check("d1234_s3", slot_a[3], 7'b0010010);
        check("d1234_s7", slot_a[7], 7'b1111001);

        conv_a(32'd99999999, done_at, busy_cnt, n_done);
        check("done_9999", done_at, 33);
        check("ovf_9999", ovf_a, 0);
        scan_a();
        for (int i = 0; i < 8; i++) check($sformatf("d9999_s%0d", i), slot_a[i], 7'b0010000);

        conv_a(32'd100000000, done_at, busy_cnt, n_done);
        check("done_ovf", done_at, 33);
        check("ovf_set", ovf_a, 1);
        scan_a();
        for (int i = 0; i < 8; i++) check($sformatf("dovf_s%0d", i), slot_a[i], 7'b0111111);

        // Load 5, then 42 while busy; the pending request starts a second conversion.
        score_a = 32'd5; load_a = 1'b1; tick(); load_a = 1'b0;
        repeat (4) tick();
        score_a = 32'd42; load_a = 1'b1; tick(); load_a = 1'b0;
        done_at = -1; n_done = 0; found = -1;
        for (int k = 6; k <= 100; k++) begin
            tick();
            if (done_a) begin
                n_done++;
                if (done_at < 0) done_at = k;
                else found = k;
            end
        end
        check("pend_first", done_at, 33);
        check("pend_second", found, 67);
        check("pend_cnt", n_done, 2);
        check("pend_clear", busy_a, 0);
        check("ovf_clear", ovf_a, 0);
        scan_a();
        check("d42_s0", slot_a[0], 7'b0100100);
        check("d42_s1", slot_a[1], 7'b0011001);
        check("d42_s2", slot_a[2], ZA);

        // Abort a conversion that also has a pending load behind it.
        score_a = 32'd12345678; load_a = 1'b1; tick(); load_a = 1'b0;
        repeat (4) tick();
        load_a = 1'b1; tick(); load_a = 1'b0;
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", busy_a, 0);
        n_done = 0; bad = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done_a) n_done++;
            if (busy_a) bad++;
        end
        check("abort_nodone", n_done, 0);
        check("abort_nobusy", bad, 0);
        check("abort_ovf", ovf_a, 0);
        scan_a();
        check("dz_s0", slot_a[0], 7'b1000000);
        for (int i = 1; i < 8; i++) check($sformatf("dz_s%0d", i), slot_a[i], ZA);

        conv_a(32'd7, done_at, busy_cnt, n_done);
        check("done_7", done_at, 33);
        scan_a();
        check("d7_s0", slot_a[0], 7'b1111000);
        for (int i = 1; i < 8; i++) check($sformatf("d7_s%0d", i), slot_a[i], ZA);

        // Small active-high instance.
        score_b = 32'd7; load_b = 1'b1; tick(); load_b = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done_b && done_at < 0) done_at = k;
        end
        check("b_done", done_at, 33);
        prev = com_b; found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            tick();
            if (com_b == 4'b0001 && prev == 4'b1000) found = 1;
            prev = com_b;
        end
        check("b_rot_found", found, 1);
        repeat (4) tick();
        check("b_com_4", com_b, 4'b0010);
        repeat (11) tick();
        check("b_com_15", com_b, 4'b1000);
        tick();
        check("b_com_16", com_b, 4'b0001);
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            tick();
            if ($countones(com_b) != 1) bad++;
            for (int i = 0; i < 4; i++) if (com_b[i]) slot_b[i] = seg_b;
        end
        check("b_onehot", bad, 0);
        check("b_s0", slot_b[0], 7'b0000111);
        for (int i = 1; i < 4; i++) check($sformatf("b_s%0d", i), slot_b[i], ZB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
